fsm_job_dispatcher: RTL

- Upstream feeder for the single-job control FSM (ports clk, rst, start, done).
- Accepts job requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one single-cycle start pulse per job, then waits for the FSM's done.
- Reports each job's completion or watchdog timeout with its job ID, so the FSM never sees a start while a job is in flight.

---
 rtl/fsm_job_dispatcher.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fsm_job_dispatcher.sv
// Job dispatcher: queues job requests and feeds them one at a time
// to a start/done control FSM, reporting completion or watchdog timeout.
module fsm_job_dispatcher #(
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32,
  parameter int TMR_W   = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  output logic             start,
  input  logic             done,
  output logic             cmp_valid,
  output logic [ID_W-1:0]  cmp_id,
  output logic             cmp_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REPORT
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMO_C   = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]    mem_q [DEPTH];
  logic [ID_W-1:0]    cur_id_q;
  logic [ID_W-1:0]    cmp_id_q;
  logic               start_q, busy_q;
  logic               cmp_valid_q, cmp_to_q;
  logic               to_d;
  logic               push, pop;

  // No full-bypass: a full FIFO refuses even when a pop is happening.
  assign req_ready = (pending_q < DEPTH_C);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (pending_q != '0);

  assign start       = start_q;
  assign busy        = busy_q;
  assign cmp_valid   = cmp_valid_q;
  assign cmp_id      = cmp_id_q;
  assign cmp_timeout = cmp_to_q;
  assign pending     = pending_q;

  // Next state, watchdog timer and timeout flag
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (done) begin
          state_d = REPORT;
        end else if (tmr_q == TMO_C) begin
          state_d = REPORT;
          to_d    = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update from push/pop
  always_comb begin
    pending_d = pending_q;
    unique case ({push, pop})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_id;
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cur_id_q    <= '0;
      cmp_id_q    <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pending_q   <= pending_d;
      start_q     <= (state_d == ISSUE);
      busy_q      <= (state_d != IDLE);
      cmp_valid_q <= (state_d == REPORT);
      cmp_to_q    <= to_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cur_id_q <= mem_q[rd_ptr_q];
      end
      if (state_q == WAIT && state_d == REPORT) cmp_id_q <= cur_id_q;
    end
  end

endmodule
